rtc_bus_responder: RTL

Synthesizable responder for the RTC multiplexed address/data bus: the chip side of the bus driven by `Controlador_RTC`. It decodes the AD/CS/RD/WR strobes, latches addresses and write data, returns read data, and keeps a BCD calendar plus a countdown timer. It replaces the external RTC chip for on-chip loopback and gives the controller bench a cycle-accurate counterpart.

---
 rtl/rtc_pkg.sv | 49 ++++
 rtl/rtc_bus_responder_if.sv | 16 +
 rtl/bcd_wrap_counter.sv | 30 +++
 rtl/rtc_bus_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and BCD arithmetic helpers for the RTC bus responder.
package rtc_pkg;

    // Register map
    localparam logic [7:0] ADDR_CTRL  = 8'h00;
    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;
    localparam logic [7:0] ADDR_TSEC  = 8'h41;
    localparam logic [7:0] ADDR_TMIN  = 8'h42;
    localparam logic [7:0] ADDR_THOUR = 8'h43;

    // Reset values: 00:00:00 on 01/01/00, timer cleared
    localparam logic [7:0] RST_SEC   = 8'h00;
    localparam logic [7:0] RST_MIN   = 8'h00;
    localparam logic [7:0] RST_HOUR  = 8'h00;
    localparam logic [7:0] RST_DAY   = 8'h01;
    localparam logic [7:0] RST_MONTH = 8'h01;
    localparam logic [7:0] RST_YEAR  = 8'h00;
    localparam logic [7:0] RST_TIMER = 8'h00;

    // Control register bit positions
    localparam int CTRL_EN_BIT   = 3;
    localparam int CTRL_DONE_BIT = 0;

    // BCD increment that wraps to lo once hi (or anything above it) is reached
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v >= hi)              r = lo;
        else if (v[3:0] >= 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = v + 8'd1;
        return r;
    endfunction

    // BCD decrement that wraps to hi once lo (or anything below it) is reached
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v <= lo)              r = hi;
        else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
        else                      r = v - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed RTC address/data bus as seen between controller and responder.
interface rtc_bus_responder_if;
    logic       ADi;
    logic       CSi;
    logic       RDi;
    logic       WRi;
    logic [7:0] AdressDatai;
    logic [7:0] AdressDatao;
    logic       DataOE;
    logic       IRQo;

    modport master (output ADi, CSi, RDi, WRi, AdressDatai,
                    input  AdressDatao, DataOE, IRQo);
    modport slave  (input  ADi, CSi, RDi, WRi, AdressDatai,
                    output AdressDatao, DataOE, IRQo);
endinterface

// File: rtl/bcd_wrap_counter.sv
// One BCD field (up or down) with load, enable and wrap carry/borrow out.
module bcd_wrap_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] RST = 8'h00,
    parameter bit         UP  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] value,
    output logic       carry
);

    // Carry (up) or borrow (down) fires when this step wraps the field
    assign carry = en & ~load & (value == (UP ? MAX : MIN));

    // Field register: bus load wins over counting
    always_ff @(posedge clock) begin
        if (!reset)     value <= RST;
        else if (load)  value <= load_val;
        else if (en)    value <= UP ? bcd_inc(value, MIN, MAX) : bcd_dec(value, MIN, MAX);
        else            value <= value;
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Chip side of the RTC bus: strobe decode, address latch, read mux, BCD
// calendar and countdown timer driven by a one-second tick.
module rtc_bus_responder
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic                clock,
    input  logic                reset,
    rtc_bus_responder_if.slave  bus
);

    localparam int             CW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICKS_PER_SEC - 1);

    logic          wr_q, rd_q, rd_qq, cs_q, ad_q;
    logic [7:0]    addr_q, rdata_q, rd_mux_s;
    logic          oe_q, irq_q, ten_q, done_q, ten_nxt, done_nxt, pend_q;
    logic [CW-1:0] tick_cnt_q;
    logic          wr_rise_s, addr_wr_s, data_wr_s, read_s, tick_s, apply_tick_s;
    logic          ld_sec_s, ld_min_s, ld_hour_s, ld_day_s, ld_month_s, ld_year_s;
    logic          ld_tsec_s, ld_tmin_s, ld_thour_s, ld_ctrl_s;
    logic [7:0]    sec_s, min_s, hour_s, day_s, month_s, year_s, tsec_s, tmin_s, thour_s;
    logic          c_sec_s, c_min_s, c_hour_s, c_day_s, c_month_s, c_year_s;
    logic          b_tsec_s, b_tmin_s, b_thour_s, tzero_s, tone_s, tdec_s;
    logic          unused_carry_s;

    // Writes act on the WR rising edge straight away; reads are decoded from
    // registered strobes so data appears one edge after RD is first sampled low.
    assign wr_rise_s = bus.WRi & ~wr_q;
    assign addr_wr_s = wr_rise_s & ~bus.CSi & ~bus.ADi;
    assign data_wr_s = wr_rise_s & ~bus.CSi & bus.ADi;
    assign read_s    = ~rd_q & rd_qq & ~cs_q & ad_q & wr_q;

    // A tick coinciding with a bus write is held one cycle so the write lands first
    assign tick_s       = (tick_cnt_q == TICK_LAST);
    assign apply_tick_s = (tick_s | pend_q) & ~data_wr_s;

    assign ld_ctrl_s  = data_wr_s & (addr_q == ADDR_CTRL);
    assign ld_sec_s   = data_wr_s & (addr_q == ADDR_SEC);
    assign ld_min_s   = data_wr_s & (addr_q == ADDR_MIN);
    assign ld_hour_s  = data_wr_s & (addr_q == ADDR_HOUR);
    assign ld_day_s   = data_wr_s & (addr_q == ADDR_DAY);
    assign ld_month_s = data_wr_s & (addr_q == ADDR_MONTH);
    assign ld_year_s  = data_wr_s & (addr_q == ADDR_YEAR);
    assign ld_tsec_s  = data_wr_s & (addr_q == ADDR_TSEC);
    assign ld_tmin_s  = data_wr_s & (addr_q == ADDR_TMIN);
    assign ld_thour_s = data_wr_s & (addr_q == ADDR_THOUR);

    assign tzero_s = (tsec_s == 8'h00) & (tmin_s == 8'h00) & (thour_s == 8'h00);
    assign tone_s  = (tsec_s == 8'h01) & (tmin_s == 8'h00) & (thour_s == 8'h00);
    assign tdec_s  = apply_tick_s & ten_q & ~tzero_s;

    assign unused_carry_s = c_year_s | b_thour_s;

    assign bus.AdressDatao = rdata_q;
    assign bus.DataOE      = oe_q;
    assign bus.IRQo        = irq_q;

    // Calendar chain: sec -> min -> hour -> day -> month -> year
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h59), .RST(RST_SEC),   .UP(1'b1)) u_sec
        (.clock(clock), .reset(reset), .load(ld_sec_s),   .load_val(bus.AdressDatai), .en(apply_tick_s), .value(sec_s),   .carry(c_sec_s));
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h59), .RST(RST_MIN),   .UP(1'b1)) u_min
        (.clock(clock), .reset(reset), .load(ld_min_s),   .load_val(bus.AdressDatai), .en(c_sec_s),      .value(min_s),   .carry(c_min_s));
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h23), .RST(RST_HOUR),  .UP(1'b1)) u_hour
        (.clock(clock), .reset(reset), .load(ld_hour_s),  .load_val(bus.AdressDatai), .en(c_min_s),      .value(hour_s),  .carry(c_hour_s));
    bcd_wrap_counter #(.MIN(8'h01), .MAX(8'h31), .RST(RST_DAY),   .UP(1'b1)) u_day
        (.clock(clock), .reset(reset), .load(ld_day_s),   .load_val(bus.AdressDatai), .en(c_hour_s),     .value(day_s),   .carry(c_day_s));
    bcd_wrap_counter #(.MIN(8'h01), .MAX(8'h12), .RST(RST_MONTH), .UP(1'b1)) u_month
        (.clock(clock), .reset(reset), .load(ld_month_s), .load_val(bus.AdressDatai), .en(c_day_s),      .value(month_s), .carry(c_month_s));
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h99), .RST(RST_YEAR),  .UP(1'b1)) u_year
        (.clock(clock), .reset(reset), .load(ld_year_s),  .load_val(bus.AdressDatai), .en(c_month_s),    .value(year_s),  .carry(c_year_s));

    // Countdown timer chain: sec borrows from min, min borrows from hour
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h59), .RST(RST_TIMER), .UP(1'b0)) u_tsec
        (.clock(clock), .reset(reset), .load(ld_tsec_s),  .load_val(bus.AdressDatai), .en(tdec_s),       .value(tsec_s),  .carry(b_tsec_s));
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h59), .RST(RST_TIMER), .UP(1'b0)) u_tmin
        (.clock(clock), .reset(reset), .load(ld_tmin_s),  .load_val(bus.AdressDatai), .en(b_tsec_s),     .value(tmin_s),  .carry(b_tmin_s));
    bcd_wrap_counter #(.MIN(8'h00), .MAX(8'h23), .RST(RST_TIMER), .UP(1'b0)) u_thour
        (.clock(clock), .reset(reset), .load(ld_thour_s), .load_val(bus.AdressDatai), .en(b_tmin_s),     .value(thour_s), .carry(b_thour_s));

    // Register strobes and qualifiers for edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q  <= 1'b1;
            rd_q  <= 1'b1;
            rd_qq <= 1'b1;
            cs_q  <= 1'b1;
            ad_q  <= 1'b0;
        end else begin
            wr_q  <= bus.WRi;
            rd_q  <= bus.RDi;
            rd_qq <= rd_q;
            cs_q  <= bus.CSi;
            ad_q  <= bus.ADi;
        end
    end

    // Address latch, held until the next address write
    always_ff @(posedge clock) begin
        if (!reset)          addr_q <= 8'h00;
        else if (addr_wr_s)  addr_q <= bus.AdressDatai;
        else                 addr_q <= addr_q;
    end

    // Read mux over the register map; unmapped addresses read zero
    always_comb begin
        rd_mux_s = 8'h00;
        case (addr_q)
            ADDR_CTRL: begin
                rd_mux_s                = 8'h00;
                rd_mux_s[CTRL_EN_BIT]   = ten_q;
                rd_mux_s[CTRL_DONE_BIT] = done_q;
            end
            ADDR_SEC:   rd_mux_s = sec_s;
            ADDR_MIN:   rd_mux_s = min_s;
            ADDR_HOUR:  rd_mux_s = hour_s;
            ADDR_DAY:   rd_mux_s = day_s;
            ADDR_MONTH: rd_mux_s = month_s;
            ADDR_YEAR:  rd_mux_s = year_s;
            ADDR_TSEC:  rd_mux_s = tsec_s;
            ADDR_TMIN:  rd_mux_s = tmin_s;
            ADDR_THOUR: rd_mux_s = thour_s;
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // Read snapshot and bus drive enable, dropped as soon as RD or CS deasserts
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= 8'h00;
            oe_q    <= 1'b0;
        end else if (read_s) begin
            rdata_q <= rd_mux_s;
            oe_q    <= 1'b1;
        end else begin
            rdata_q <= rdata_q;
            oe_q    <= oe_q & ~bus.RDi & ~bus.CSi;
        end
    end

    // One-second divider and the deferred-tick flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt_q <= {CW{1'b0}};
            pend_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_s ? {CW{1'b0}} : tick_cnt_q + CW'(1);
            pend_q     <= (tick_s | pend_q) & data_wr_s;
        end
    end

    // Timer enable/done: a control write wins, otherwise reaching zero ends the count
    always_comb begin
        ten_nxt  = ten_q;
        done_nxt = done_q;
        if (ld_ctrl_s) begin
            ten_nxt  = bus.AdressDatai[CTRL_EN_BIT];
            done_nxt = bus.AdressDatai[CTRL_DONE_BIT];
        end else if (apply_tick_s & ten_q & (tzero_s | tone_s)) begin
            ten_nxt  = 1'b0;
            done_nxt = 1'b1;
        end else begin
            ten_nxt  = ten_q;
            done_nxt = done_q;
        end
    end

    // Control state and the active-low interrupt that mirrors done
    always_ff @(posedge clock) begin
        if (!reset) begin
            ten_q  <= 1'b0;
            done_q <= 1'b0;
            irq_q  <= 1'b1;
        end else begin
            ten_q  <= ten_nxt;
            done_q <= done_nxt;
            irq_q  <= ~done_nxt;
        end
    end

endmodule
